// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS run monitor and its trace buffer.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] result;
    } trace_entry_t;

endpackage

// File: rtl/mips_trace_buf.sv
// Circular trace of (instruction, result) pairs with saturating fill count;
// reads are indexed relative to the most recent write.
module mips_trace_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       we_i,
    input  logic [DATA_W-1:0]          instr_i,
    input  logic [DATA_W-1:0]          result_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [DATA_W-1:0]          rd_instr_o,
    output logic [DATA_W-1:0]          rd_result_o,
    output logic [$clog2(DEPTH):0]     fill_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] instr_mem  [DEPTH];
    logic [DATA_W-1:0] result_mem [DEPTH];
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW:0]       fill_q, fill_d;
    logic [AW-1:0]     rd_ptr;

    always_comb begin
        wp_d   = wp_q;
        fill_d = fill_q;
        if (clr_i) begin
            wp_d   = '0;
            fill_d = '0;
        end else if (we_i) begin
            wp_d = wp_q + AW'(1);
            if (fill_q != FULL) fill_d = fill_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q   <= '0;
            fill_q <= '0;
        end else begin
            wp_q   <= wp_d;
            fill_q <= fill_d;
        end
    end

    // Contents are deliberately not reset; fill_q gates every read.
    always_ff @(posedge clk_i) begin
        if (we_i && !clr_i) begin
            instr_mem[wp_q]  <= instr_i;
            result_mem[wp_q] <= result_i;
        end
    end

    assign rd_ptr = wp_q - AW'(1) - rd_idx_i;

    always_comb begin
        rd_instr_o  = '0;
        rd_result_o = '0;
        if ({1'b0, rd_idx_i} < fill_q) begin
            rd_instr_o  = instr_mem[rd_ptr];
            rd_result_o = result_mem[rd_ptr];
        end
    end

    assign fill_o = fill_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor beside the MIPS core: NOP-run halt detection, watchdog timeout,
// cycle/instruction counters and a trace of recent retired instructions.
module mips_run_monitor
    import mips_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int NOP_THRESHOLD  = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16,
    parameter int TRACE_DEPTH    = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic                               clear_i,
    input  logic                               instr_valid_i,
    input  logic [DATA_W-1:0]                  instr_i,
    input  logic [DATA_W-1:0]                  result_i,
    output logic [1:0]                         state_o,
    output logic                               halted_o,
    output logic                               timeout_o,
    output logic [CNT_W-1:0]                   cycle_count_o,
    output logic [CNT_W-1:0]                   instr_count_o,
    output logic [$clog2(NOP_THRESHOLD+1)-1:0] nop_run_o,
    input  logic [$clog2(TRACE_DEPTH)-1:0]     trace_rd_idx_i,
    output logic [DATA_W-1:0]                  trace_rd_instr_o,
    output logic [DATA_W-1:0]                  trace_rd_result_o,
    output logic [$clog2(TRACE_DEPTH):0]       trace_fill_o
);
    localparam int NW = $clog2(NOP_THRESHOLD+1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d, icnt_q, icnt_d;
    logic [NW-1:0]     nop_q, nop_d, nop_inc;
    logic              halted_q, halted_d, timeout_q, timeout_d;
    logic              is_nop, trace_we, trace_clr;

    assign is_nop  = (instr_i == DATA_W'(NOP_WORD));
    assign nop_inc = nop_q + NW'(1);

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        icnt_d    = icnt_q;
        nop_d     = nop_q;
        trace_we  = 1'b0;
        trace_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    cycle_d   = '0;
                    icnt_d    = '0;
                    nop_d     = '0;
                    trace_clr = 1'b1;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_q + CNT_W'(1);
                if (instr_valid_i) begin
                    if (is_nop) begin
                        nop_d = nop_inc;
                    end else begin
                        nop_d    = '0;
                        icnt_d   = icnt_q + CNT_W'(1);
                        trace_we = 1'b1;
                    end
                end
                // Halt takes priority when both land on the same edge.
                if (instr_valid_i && is_nop && nop_inc == NW'(NOP_THRESHOLD))
                    state_d = ST_HALTED;
                else if (cycle_d == CNT_W'(TIMEOUT_CYCLES))
                    state_d = ST_TIMEOUT;
            end
            ST_HALTED, ST_TIMEOUT: begin
                if (clear_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        halted_d  = (state_d == ST_HALTED);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cycle_q   <= '0;
            icnt_q    <= '0;
            nop_q     <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            icnt_q    <= icnt_d;
            nop_q     <= nop_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

    mips_trace_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .clk_i       (clk_i),
        .rst_i       (reset_i),
        .clr_i       (trace_clr),
        .we_i        (trace_we),
        .instr_i     (instr_i),
        .result_i    (result_i),
        .rd_idx_i    (trace_rd_idx_i),
        .rd_instr_o  (trace_rd_instr_o),
        .rd_result_o (trace_rd_result_o),
        .fill_o      (trace_fill_o)
    );

    assign state_o       = state_q;
    assign halted_o      = halted_q;
    assign timeout_o     = timeout_q;
    assign cycle_count_o = cycle_q;
    assign instr_count_o = icnt_q;
    assign nop_run_o     = nop_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: a vector table for the main flows plus
// hand-written sequences for async reset, timeout and halt/timeout collision.
module tb_mips_run_monitor;

    logic        clk = 1'b0;
    logic        reset, start, clear, valid;
    logic [31:0] instr, result;
    logic [1:0]  rd_idx;

    // Instance A: defaults. B: short timeout. C: short timeout, threshold 1.
    logic [1:0]  st_a, st_b, st_c;
    logic        h_a, h_b, h_c, t_a, t_b, t_c;
    logic [15:0] cyc_a, cyc_b, cyc_c, ic_a, ic_b, ic_c;
    logic [1:0]  nop_a, nop_b;
    logic [0:0]  nop_c;
    logic [31:0] ri_a, ri_b, ri_c, rr_a, rr_b, rr_c;
    logic [2:0]  f_a, f_b, f_c;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mips_run_monitor u_a (
        .clk_i(clk), .reset_i(reset), .start_i(start), .clear_i(clear),
        .instr_valid_i(valid), .instr_i(instr), .result_i(result),
        .state_o(st_a), .halted_o(h_a), .timeout_o(t_a),
        .cycle_count_o(cyc_a), .instr_count_o(ic_a), .nop_run_o(nop_a),
        .trace_rd_idx_i(rd_idx), .trace_rd_instr_o(ri_a),
        .trace_rd_result_o(rr_a), .trace_fill_o(f_a));

    mips_run_monitor #(.TIMEOUT_CYCLES(8)) u_b (
        .clk_i(clk), .reset_i(reset), .start_i(start), .clear_i(clear),
        .instr_valid_i(valid), .instr_i(instr), .result_i(result),
        .state_o(st_b), .halted_o(h_b), .timeout_o(t_b),
        .cycle_count_o(cyc_b), .instr_count_o(ic_b), .nop_run_o(nop_b),
        .trace_rd_idx_i(rd_idx), .trace_rd_instr_o(ri_b),
        .trace_rd_result_o(rr_b), .trace_fill_o(f_b));

    mips_run_monitor #(.TIMEOUT_CYCLES(8), .NOP_THRESHOLD(1)) u_c (
        .clk_i(clk), .reset_i(reset), .start_i(start), .clear_i(clear),
        .instr_valid_i(valid), .instr_i(instr), .result_i(result),
        .state_o(st_c), .halted_o(h_c), .timeout_o(t_c),
        .cycle_count_o(cyc_c), .instr_count_o(ic_c), .nop_run_o(nop_c),
        .trace_rd_idx_i(rd_idx), .trace_rd_instr_o(ri_c),
        .trace_rd_result_o(rr_c), .trace_fill_o(f_c));

    typedef struct {
        logic        st, cl, vl;
        logic [31:0] ins, res;
        logic [1:0]  e_state;
        logic        e_h, e_t;
        int          e_cyc, e_ic, e_nop, e_fill;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic st, logic cl, logic vl, logic [31:0] ins,
                                logic [31:0] res, logic [1:0] es, logic eh,
                                logic et, int ec, int ei, int en, int ef);
        vec_t v;
        v.st = st; v.cl = cl; v.vl = vl; v.ins = ins; v.res = res;
        v.e_state = es; v.e_h = eh; v.e_t = et;
        v.e_cyc = ec; v.e_ic = ei; v.e_nop = en; v.e_fill = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic cl, input logic vl,
                         input logic [31:0] ins, input logic [31:0] res);
        start = st; clear = cl; valid = vl; instr = ins; result = res;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].st, vecs[i].cl, vecs[i].vl, vecs[i].ins, vecs[i].res);
            step();
            chk($sformatf("row%0d state", i),  64'(st_a),  64'(vecs[i].e_state));
            chk($sformatf("row%0d halted", i), 64'(h_a),   64'(vecs[i].e_h));
            chk($sformatf("row%0d timeout", i), 64'(t_a),  64'(vecs[i].e_t));
            chk($sformatf("row%0d cycles", i), 64'(cyc_a), 64'(vecs[i].e_cyc));
            chk($sformatf("row%0d instrs", i), 64'(ic_a),  64'(vecs[i].e_ic));
            chk($sformatf("row%0d nop_run", i), 64'(nop_a), 64'(vecs[i].e_nop));
            chk($sformatf("row%0d fill", i),   64'(f_a),   64'(vecs[i].e_fill));
        end
        drive(0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Test 1: addi / add then three NOPs -> halt.
        vecs[0]  = mk(1,0,0,32'h0,       32'h0,        2'd1,0,0, 0,0,0,0);
        vecs[1]  = mk(0,0,1,32'h200a000a,32'h0000000a, 2'd1,0,0, 1,1,0,1);
        vecs[2]  = mk(0,0,1,32'h016a5820,32'h00000014, 2'd1,0,0, 2,2,0,2);
        vecs[3]  = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 3,2,1,2);
        vecs[4]  = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 4,2,2,2);
        vecs[5]  = mk(0,0,1,32'h0,       32'h0,        2'd2,1,0, 5,2,3,2);
        // Test 2: clear, restart, NOP NOP instr NOP NOP NOP.
        vecs[6]  = mk(0,1,0,32'h0,       32'h0,        2'd0,0,0, 5,2,3,2);
        vecs[7]  = mk(1,0,0,32'h0,       32'h0,        2'd1,0,0, 0,0,0,0);
        vecs[8]  = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 1,0,1,0);
        vecs[9]  = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 2,0,2,0);
        vecs[10] = mk(0,0,1,32'h8c0b0004,32'h00000004, 2'd1,0,0, 3,1,0,1);
        vecs[11] = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 4,1,1,1);
        vecs[12] = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 5,1,2,1);
        vecs[13] = mk(0,0,1,32'h0,       32'h0,        2'd2,1,0, 6,1,3,1);
        // Test 6: start ignored in HALTED, clear, restart, invalid cycles.
        vecs[14] = mk(1,0,1,32'h12345678,32'h1,        2'd2,1,0, 6,1,3,1);
        vecs[15] = mk(0,1,0,32'h0,       32'h0,        2'd0,0,0, 6,1,3,1);
        vecs[16] = mk(0,0,1,32'h12345678,32'h1,        2'd0,0,0, 6,1,3,1);
        vecs[17] = mk(1,0,0,32'h0,       32'h0,        2'd1,0,0, 0,0,0,0);
        vecs[18] = mk(0,0,0,32'h12345678,32'h1,        2'd1,0,0, 1,0,0,0);
        vecs[19] = mk(0,1,0,32'h0,       32'h0,        2'd1,0,0, 2,0,0,0);
        vecs[20] = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 3,0,1,0);
        vecs[21] = mk(0,0,0,32'h0,       32'h0,        2'd1,0,0, 4,0,1,0);
        vecs[22] = mk(0,0,1,32'h0,       32'h0,        2'd1,0,0, 5,0,2,0);
        vecs[23] = mk(0,0,1,32'h0badf00d,32'h0000beef, 2'd1,0,0, 6,1,0,1);

        rd_idx = 2'd0;
        drive(0, 0, 0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (2) step();
        chk("reset state",   64'(st_a),  64'd0);
        chk("reset halted",  64'(h_a),   64'd0);
        chk("reset timeout", 64'(t_a),   64'd0);
        chk("reset cycles",  64'(cyc_a), 64'd0);
        chk("reset instrs",  64'(ic_a),  64'd0);
        chk("reset nop_run", 64'(nop_a), 64'd0);
        chk("reset fill",    64'(f_a),   64'd0);
        reset = 1'b0;

        run_rows(0, 5);
        rd_idx = 2'd0; #1;
        chk("t1 idx0 instr",  64'(ri_a), 64'h016a5820);
        chk("t1 idx0 result", 64'(rr_a), 64'h00000014);
        rd_idx = 2'd1; #1;
        chk("t1 idx1 instr",  64'(ri_a), 64'h200a000a);
        chk("t1 idx1 result", 64'(rr_a), 64'h0000000a);
        rd_idx = 2'd2; #1;
        chk("t1 idx2 empty",  64'(ri_a), 64'h0);
        chk("t1 idx2 empty r", 64'(rr_a), 64'h0);

        run_rows(6, 13);
        rd_idx = 2'd0; #1;
        chk("t2 idx0 instr", 64'(ri_a), 64'h8c0b0004);
        rd_idx = 2'd1; #1;
        chk("t2 idx1 empty", 64'(ri_a), 64'h0);

        run_rows(14, 23);

        // Test 5: asynchronous reset between edges.
        #3 reset = 1'b1;
        #1;
        chk("async rst state",  64'(st_a),  64'd0);
        chk("async rst cycles", 64'(cyc_a), 64'd0);
        chk("async rst instrs", 64'(ic_a),  64'd0);
        chk("async rst fill",   64'(f_a),   64'd0);
        #2 reset = 1'b0;

        // Test 3: only non-NOPs on a TIMEOUT_CYCLES=8 monitor.
        do_reset();
        drive(1, 0, 0, 32'h0, 32'h0);
        step();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 1, 32'h1000_0000 + 32'(k), 32'h0000_00a0 + 32'(k));
            step();
            if (k == 7) begin
                chk("t3 run at 7",    64'(st_b),  64'd1);
                chk("t3 cycles at 7", 64'(cyc_b), 64'd7);
            end
        end
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("t3 state",   64'(st_b),  64'd3);
        chk("t3 timeout", 64'(t_b),   64'd1);
        chk("t3 halted",  64'(h_b),   64'd0);
        chk("t3 cycles",  64'(cyc_b), 64'd8);
        chk("t3 instrs",  64'(ic_b),  64'd8);
        chk("t3 fill",    64'(f_b),   64'd4);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            chk($sformatf("t3 idx%0d instr", i),  64'(ri_b), 64'h1000_0000 + 64'(8 - i));
            chk($sformatf("t3 idx%0d result", i), 64'(rr_b), 64'h0000_00a0 + 64'(8 - i));
        end
        rd_idx = 2'd0;
        drive(0, 0, 1, 32'h7777_7777, 32'h1);
        step();
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("t3 frozen cycles", 64'(cyc_b), 64'd8);
        chk("t3 frozen instrs", 64'(ic_b),  64'd8);
        chk("t3 frozen idx0",   64'(ri_b),  64'h1000_0008);

        // Test 4: halt and timeout on the same edge, NOP_THRESHOLD=1.
        do_reset();
        drive(1, 0, 0, 32'h0, 32'h0);
        step();
        for (int k = 1; k <= 7; k++) begin
            drive(0, 0, 1, 32'h2000_0000 + 32'(k), 32'(k));
            step();
        end
        drive(0, 0, 1, 32'h0, 32'h0);
        step();
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("t4 state",   64'(st_c),  64'd2);
        chk("t4 halted",  64'(h_c),   64'd1);
        chk("t4 timeout", 64'(t_c),   64'd0);
        chk("t4 cycles",  64'(cyc_c), 64'd8);
        chk("t4 instrs",  64'(ic_c),  64'd7);
        chk("t4 nop_run", 64'(nop_c), 64'd1);
        chk("t4 thr3 times out", 64'(st_b), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
